vjtag_dr_bank: RTL and testbench
================================

# vjtag_dr_bank

Parametrised multi-channel virtual-JTAG data-register bank. One shared DR shift register is routed by the virtual IR to any of NUM_CH write channels, a read-only status register, or a 1-bit bypass. Shifted length is checked before any commit, and each channel drives its own registered output word with a one-cycle update strobe. Sits between the vJTAG hub (tck, ir_in, capture/shift/update flags) and the pattern-generation logic on the DE0 fabric.

## Interface
- DR_WIDTH, 644: bits per channel word; must be ≥16.
- NUM_CH, 4: number of write channels; must be ≤ 2^IR_WIDTH−2.
- IR_WIDTH, 3: virtual IR width.
- tck  in  1  JTAG clock; all state changes on its rising edge.
- aclr  in  1  reset, synchronous, active-high.
- tdi  in  1  serial data in.
- ir_in  in  IR_WIDTH  virtual IR.
- v_cdr  in  1  Capture-DR flag.
- v_sdr  in  1  Shift-DR flag.
- v_udr  in  1  Update-DR flag.
- tdo  out  1  serial data out (combinational mux).
- out_bus  out  NUM_CH*DR_WIDTH  channel k occupies bits [k*DR_WIDTH +: DR_WIDTH].
- upd_stb  out  NUM_CH  one-cycle commit pulse per channel.
- len_err  out  1  last update had a bad shift length.
- upd_cnt  out  8  count of successful commits, wraps.

## Operation
- IR decode: 0 = BYPASS; 1..NUM_CH = channel ir_in−1; all-ones = STATUS; any other value = BYPASS.
- Bypass reg loads tdi every tck edge regardless of IR.
- Shift reg sr[DR_WIDTH-1:0], LSB first: on v_sdr with a channel or STATUS IR, sr <= {tdi, sr[DR_WIDTH-1:1]}. No change when the IR is BYPASS.
- tdo = sr[0] for channel/STATUS IR, else bypass reg.
- Capture (v_cdr):
  - Clears the shift counter.
  - STATUS IR loads sr[15:0] = {3'b0, len_err, last_ch[3:0], upd_cnt} and zeroes the upper bits of sr.
  - Channel capture: see Configuration.
- Shift counter: increments on each v_sdr edge with a non-BYPASS IR and saturates at DR_WIDTH+1.
- Update (v_udr) with channel IR k:
  - If count == DR_WIDTH: out word k <= sr, upd_stb[k] pulses, upd_cnt++, last_ch <= k, len_err <= 0.
  - Otherwise: no commit, len_err <= 1.
- Update with STATUS or BYPASS IR: no effect.
- Priority within one edge: aclr > v_cdr > v_sdr > v_udr.
- ir_in is sampled each edge. An IR change mid-shift keeps the sr contents; the commit target is ir_in at v_udr.

## Timing
- Reset (aclr high at an edge) clears sr, bypass reg, counter, out_bus, upd_stb, len_err, upd_cnt and last_ch to 0.
- aclr asserted mid-shift discards the partial word.
- Commit latency: out word k, upd_stb[k], upd_cnt and len_err are all valid after the edge that samples v_udr.
- upd_stb is high for exactly one tck cycle.
- upd_cnt wraps 255 → 0.
- tdo reflects the post-edge sr[0] in the same cycle (no pipeline stage).
- Counter saturation: a shift of DR_WIDTH+5 bits still reads DR_WIDTH+1 and gives len_err.
- Zero-length shift (capture then update) gives len_err.

## Configuration
- VJTAG_READBACK_EN defined: Capture-DR with channel IR k loads sr <= out word k, so the shift-out returns the currently committed word.
- Undefined: channel capture leaves sr unchanged, and tdo returns the previous shift contents.
- Status capture and length checking behave the same with or without the macro.

## Structure
- Package vjtag_pkg holds:
  - IR_BYPASS constant;
  - function returning the all-ones STATUS code for a given IR_WIDTH;
  - STATUS_W = 16 and the status field offsets;
  - a function computing the counter width, clog2(DR_WIDTH+2).
- Sub-module vjtag_shift_ctr: saturating, clearable length counter; outputs a count_ok flag (count == DR_WIDTH).

## Test plan
Bench instance uses DR_WIDTH=16, NUM_CH=4, IR_WIDTH=3.
- Reset then idle: out_bus=0, upd_stb=0, len_err=0, upd_cnt=0; tdo follows tdi delayed one cycle under IR=0.
- IR=2, capture, shift 16 bits of 0xA5C3 LSB first, update: out word 1 = 0xA5C3, upd_stb=4'b0010 for one cycle, upd_cnt=1.
- IR=3, shift 15 bits, update: out word 2 unchanged, no strobe, len_err=1. Then a correct 16-bit shift of 0x1234 gives word 2 = 0x1234 and len_err=0.
- IR=7, capture, shift 16 bits: tdo stream reads {len_err, last_ch, upd_cnt}, e.g. 0x0202 after two commits with the last to channel 2 (ir_in=3); out_bus unchanged.
- VJTAG_READBACK_EN: IR=2, capture, shift 16 zeros: tdo returns 0xA5C3 LSB first; the commit then writes 0x0000.
- aclr pulsed after 8 shifted bits, then update: no commit, all outputs 0, len_err=1.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared constants and helpers for the virtual-JTAG DR bank: IR codes,
// status word layout and shift-counter sizing.
package vjtag_pkg;

  localparam int IR_BYPASS = 0;

  localparam int STATUS_W     = 16;
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 8;
  localparam int STAT_CH_LSB  = 8;
  localparam int STAT_CH_W    = 4;
  localparam int STAT_ERR_BIT = 12;

  function automatic int status_code(input int ir_width);
    return (1 << ir_width) - 1;
  endfunction

  // Counter must hold DR_WIDTH+1 so an over-long shift is distinguishable.
  function automatic int ctr_width(input int dr_width);
    return $clog2(dr_width + 2);
  endfunction

endpackage

// File: rtl/vjtag_shift_ctr.sv
// Saturating shift-length counter, cleared on Capture-DR; count_ok marks an
// exact DR_WIDTH-bit shift.
module vjtag_shift_ctr
  import vjtag_pkg::*;
#(
  parameter int DR_WIDTH = 644,
  parameter int CW       = ctr_width(DR_WIDTH)
) (
  input  logic          tck,
  input  logic          aclr,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          count_ok
);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DR_WIDTH + 1);
  localparam logic [CW-1:0] CNT_EXACT = CW'(DR_WIDTH);

  always_ff @(posedge tck) begin
    if (aclr) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign count_ok = (count == CNT_EXACT);

endmodule

// File: rtl/vjtag_dr_bank.sv
// Multi-channel virtual-JTAG DR bank: one shared shift register routed by IR to
// NUM_CH write channels, a status word or bypass. VJTAG_READBACK_EN enables channel readback on capture.
module vjtag_dr_bank
  import vjtag_pkg::*;
#(
  parameter int DR_WIDTH = 644,
  parameter int NUM_CH   = 4,
  parameter int IR_WIDTH = 3
) (
  input  logic                       tck,
  input  logic                       aclr,
  input  logic                       tdi,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       v_cdr,
  input  logic                       v_sdr,
  input  logic                       v_udr,
  output logic                       tdo,
  output logic [NUM_CH*DR_WIDTH-1:0] out_bus,
  output logic [NUM_CH-1:0]          upd_stb,
  output logic                       len_err,
  output logic [7:0]                 upd_cnt
);

  localparam int                  CW        = ctr_width(DR_WIDTH);
  localparam logic [IR_WIDTH-1:0] IR_STATUS = IR_WIDTH'(status_code(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_NCH    = IR_WIDTH'(NUM_CH);
  localparam logic [IR_WIDTH-1:0] IR_BYP    = IR_WIDTH'(IR_BYPASS);

  logic                is_ch;
  logic                is_stat;
  logic [IR_WIDTH-1:0] ch_idx;
  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] stat_word;
  logic                byp;
  logic [3:0]          last_ch;
  logic [CW-1:0]       count;
  logic                count_ok;
  logic                commit;

  assign is_ch   = (ir_in != IR_BYP) && (ir_in <= IR_NCH);
  assign is_stat = (ir_in == IR_STATUS);
  assign ch_idx  = ir_in - IR_WIDTH'(1);

  always_comb begin
    stat_word = '0;
    stat_word[STAT_CNT_LSB +: STAT_CNT_W] = upd_cnt;
    stat_word[STAT_CH_LSB +: STAT_CH_W]   = last_ch;
    stat_word[STAT_ERR_BIT]               = len_err;
  end

  vjtag_shift_ctr #(
    .DR_WIDTH (DR_WIDTH),
    .CW       (CW)
  ) u_ctr (
    .tck      (tck),
    .aclr     (aclr),
    .clr      (v_cdr),
    .inc      (v_sdr && (is_ch || is_stat)),
    .count    (count),
    .count_ok (count_ok)
  );

  always_ff @(posedge tck) begin
    if (aclr) begin
      sr  <= '0;
      byp <= 1'b0;
    end else begin
      byp <= tdi;
      if (v_cdr) begin
        if (is_stat) begin
          sr <= stat_word;
        end
`ifdef VJTAG_READBACK_EN
        else if (is_ch) begin
          sr <= out_bus[ch_idx*DR_WIDTH +: DR_WIDTH];
        end
`endif
      end else if (v_sdr && (is_ch || is_stat)) begin
        sr <= {tdi, sr[DR_WIDTH-1:1]};
      end
    end
  end

  // Capture and shift outrank update on the same edge.
  assign commit = v_udr && !v_cdr && !v_sdr && is_ch;

  always_ff @(posedge tck) begin
    if (aclr) begin
      out_bus <= '0;
      upd_stb <= '0;
      len_err <= 1'b0;
      upd_cnt <= '0;
      last_ch <= '0;
    end else begin
      upd_stb <= '0;
      if (commit) begin
        if (count_ok) begin
          out_bus[ch_idx*DR_WIDTH +: DR_WIDTH] <= sr;
          upd_stb[ch_idx] <= 1'b1;
          upd_cnt         <= upd_cnt + 8'd1;
          last_ch         <= 4'(ch_idx);
          len_err         <= 1'b0;
        end else begin
          len_err <= 1'b1;
        end
      end
    end
  end

  assign tdo = (is_ch || is_stat) ? sr[0] : byp;

endmodule

// File: tb/tb_vjtag_dr_bank.sv
// Directed bench for vjtag_dr_bank with DR_WIDTH=16, NUM_CH=4, IR_WIDTH=3.
module tb_vjtag_dr_bank;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int IW = 3;

  logic             tck = 1'b0;
  logic             aclr;
  logic             tdi;
  logic [IW-1:0]    ir_in;
  logic             v_cdr;
  logic             v_sdr;
  logic             v_udr;
  logic             tdo;
  logic [NC*DW-1:0] out_bus;
  logic [NC-1:0]    upd_stb;
  logic             len_err;
  logic [7:0]       upd_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] got;

  vjtag_dr_bank #(.DR_WIDTH(DW), .NUM_CH(NC), .IR_WIDTH(IW)) dut (
    .tck     (tck),
    .aclr    (aclr),
    .tdi     (tdi),
    .ir_in   (ir_in),
    .v_cdr   (v_cdr),
    .v_sdr   (v_sdr),
    .v_udr   (v_udr),
    .tdo     (tdo),
    .out_bus (out_bus),
    .upd_stb (upd_stb),
    .len_err (len_err),
    .upd_cnt (upd_cnt)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture();
    v_cdr = 1'b1;
    tick();
    v_cdr = 1'b0;
  endtask

  // Shifts n bits of w LSB first; returns the bits seen on tdo before each edge.
  task automatic shift(input logic [15:0] w, input int n, output logic [15:0] tdo_bits);
    tdo_bits = '0;
    for (int i = 0; i < n; i++) begin
      tdi   = (i < 16) ? w[i] : 1'b0;
      v_sdr = 1'b1;
      if (i < 16) tdo_bits[i] = tdo;
      tick();
    end
    v_sdr = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic update();
    v_udr = 1'b1;
    tick();
    v_udr = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; tdi = 1'b0; ir_in = '0; v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0;
    tick();
    aclr = 1'b0;
    check("rst_out_bus", 64'(out_bus), 64'h0);
    check("rst_upd_stb", 64'(upd_stb), 64'h0);
    check("rst_len_err", 64'(len_err), 64'h0);
    check("rst_upd_cnt", 64'(upd_cnt), 64'h0);

    // Bypass: tdo is tdi delayed one edge.
    tdi = 1'b1; tick(); check("byp_1", 64'(tdo), 64'h1);
    tdi = 1'b0; tick(); check("byp_0", 64'(tdo), 64'h0);
    tdi = 1'b1; tick(); check("byp_1b", 64'(tdo), 64'h1);
    tdi = 1'b0;

    // Channel 1 commit.
    ir_in = 3'd2;
    capture();
    shift(16'hA5C3, 16, got);
    update();
    check("ch1_word", 64'(out_bus[31:16]), 64'hA5C3);
    check("ch1_stb", 64'(upd_stb), 64'h2);
    check("ch1_cnt", 64'(upd_cnt), 64'h1);
    check("ch1_err", 64'(len_err), 64'h0);
    tick();
    check("ch1_stb_off", 64'(upd_stb), 64'h0);

    // Short shift to channel 2 is rejected, then a correct one commits.
    ir_in = 3'd3;
    capture();
    shift(16'hFFFF, 15, got);
    update();
    check("short_word", 64'(out_bus[47:32]), 64'h0);
    check("short_stb", 64'(upd_stb), 64'h0);
    check("short_err", 64'(len_err), 64'h1);
    check("short_cnt", 64'(upd_cnt), 64'h1);
    capture();
    shift(16'h1234, 16, got);
    update();
    check("ch2_word", 64'(out_bus[47:32]), 64'h1234);
    check("ch2_stb", 64'(upd_stb), 64'h4);
    check("ch2_err", 64'(len_err), 64'h0);
    check("ch2_cnt", 64'(upd_cnt), 64'h2);

    // Status readout; update under STATUS must do nothing.
    ir_in = 3'd7;
    capture();
    shift(16'h0000, 16, got);
    check("status_word", 64'(got), 64'h0202);
    update();
    check("status_bus", out_bus, 64'h0000_1234_A5C3_0000);
    check("status_stb", 64'(upd_stb), 64'h0);
    check("status_cnt", 64'(upd_cnt), 64'h2);

    // Channel capture: readback of committed word or stale shift contents.
    ir_in = 3'd2;
    capture();
    shift(16'h0000, 16, got);
`ifdef VJTAG_READBACK_EN
    check("readback", 64'(got), 64'hA5C3);
`else
    check("no_readback", 64'(got), 64'h0000);
`endif
    update();
    check("ch1_zero", 64'(out_bus[31:16]), 64'h0);
    check("ch1_zero_cnt", 64'(upd_cnt), 64'h3);

    // Over-long shift saturates and is rejected.
    ir_in = 3'd1;
    capture();
    shift(16'h5555, 21, got);
    update();
    check("sat_err", 64'(len_err), 64'h1);
    check("sat_word", 64'(out_bus[15:0]), 64'h0);
    check("sat_stb", 64'(upd_stb), 64'h0);

    // Channel 3 commit, then a zero-length update.
    ir_in = 3'd4;
    capture();
    shift(16'hBEEF, 16, got);
    update();
    check("ch3_word", 64'(out_bus[63:48]), 64'hBEEF);
    check("ch3_stb", 64'(upd_stb), 64'h8);
    check("ch3_err", 64'(len_err), 64'h0);
    check("ch3_cnt", 64'(upd_cnt), 64'h4);
    capture();
    update();
    check("zero_len_err", 64'(len_err), 64'h1);
    check("zero_len_word", 64'(out_bus[63:48]), 64'hBEEF);
    check("zero_len_cnt", 64'(upd_cnt), 64'h4);

    // Reset mid-shift discards the partial word.
    ir_in = 3'd2;
    capture();
    shift(16'hFFFF, 8, got);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    check("aclr_bus", out_bus, 64'h0);
    check("aclr_err", 64'(len_err), 64'h0);
    check("aclr_cnt", 64'(upd_cnt), 64'h0);
    update();
    check("post_aclr_bus", out_bus, 64'h0);
    check("post_aclr_stb", 64'(upd_stb), 64'h0);
    check("post_aclr_cnt", 64'(upd_cnt), 64'h0);
    check("post_aclr_err", 64'(len_err), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
